tm1638_serial_io: RTL and testbench

Byte-level serial PHY for the TM1638 LED/key controller. It sits directly downstream of the TM1638 driver state machine, which issues command/data bytes and key-read requests one byte at a time over a valid/ready handshake. It generates the STB/CLK/DIO waveforms: LSB-first writes, key-scan reads with DIO released, and STB framing across multi-byte transfers. Read bytes are returned to the driver, which assembles the key-scan words.

---
 rtl/tm1638_serial_io.sv | 219 +++++++++++++++++++++
 tb/tb_tm1638_serial_io.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_serial_io.sv
// rtl/tm1638_serial_io.sv - byte-level STB/CLK/DIO serial PHY for the TM1638
//
// Purpose: accepts one byte request at a time from the TM1638 driver and
// produces the STB/CLK/DIO waveforms (LSB-first writes, key-scan reads with
// DIO released, STB framing across multi-byte transfers).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   req_valid/req_ready request handshake; ready only in IDLE
//   req_byte            byte to write (ignored for reads)
//   req_read            1 = read one byte from the chip
//   req_last            1 = raise STB after this byte
//   rsp_valid/rsp_byte  one-cycle pulse / held value of the last read byte
//   tm_stb, tm_clk      TM1638 strobe (active low) and clock (idles high)
//   tm_dio_out/_oe      DIO drive value and output enable
//   tm_dio_in           asynchronous DIO pad input

module tm1638_serial_io #(
  parameter int CLK_DIV   = 25,
  parameter int READ_WAIT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_byte,
  input  logic       req_read,
  input  logic       req_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_byte,
  output logic       tm_stb,
  output logic       tm_clk,
  output logic       tm_dio_out,
  output logic       tm_dio_oe,
  input  logic       tm_dio_in
);

  localparam int CNT_MAX = (CLK_DIV > READ_WAIT) ? CLK_DIV : READ_WAIT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_STB_SETUP, S_RD_WAIT, S_BIT_LO,
    S_BIT_HI, S_GAP, S_STB_HOLD, S_STB_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          read_q, read_d;
  logic          last_q, last_d;
  logic          frame_open_q, frame_open_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rsp_byte_q, rsp_byte_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          dio_meta_q, dio_sync_q;
  logic          stb_q, stb_d, clk_q, clk_d, oe_q, oe_d, out_q, out_d;

  logic       phase_done;
  logic [7:0] shift_in;

  assign phase_done = (cnt_q == '0);
  // Bits arrive LSB first, so each new bit enters at the top and shifts down.
  assign shift_in   = {dio_sync_q, shift_q[7:1]};

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_byte   = rsp_byte_q;
  assign tm_stb     = stb_q;
  assign tm_clk     = clk_q;
  assign tm_dio_oe  = oe_q;
  assign tm_dio_out = out_q;

  // State and datapath registers. Pin values are registered from the
  // next-state decode so the pads never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      read_q       <= 1'b0;
      last_q       <= 1'b0;
      frame_open_q <= 1'b0;
      shift_q      <= '0;
      rsp_byte_q   <= '0;
      rsp_valid_q  <= 1'b0;
      dio_meta_q   <= 1'b1;
      dio_sync_q   <= 1'b1;
      stb_q        <= 1'b1;
      clk_q        <= 1'b1;
      oe_q         <= 1'b0;
      out_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      read_q       <= read_d;
      last_q       <= last_d;
      frame_open_q <= frame_open_d;
      shift_q      <= shift_d;
      rsp_byte_q   <= rsp_byte_d;
      rsp_valid_q  <= rsp_valid_d;
      dio_meta_q   <= tm_dio_in;
      dio_sync_q   <= dio_meta_q;
      stb_q        <= stb_d;
      clk_q        <= clk_d;
      oe_q         <= oe_d;
      out_q        <= out_d;
    end
  end

  // Next-state logic; cnt_q counts down the cycles left in the current phase.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    read_d       = read_q;
    last_d       = last_q;
    frame_open_d = frame_open_q;
    shift_d      = shift_q;
    rsp_byte_d   = rsp_byte_q;
    rsp_valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          byte_d = req_byte;
          read_d = req_read;
          last_d = req_last;
          bit_d  = '0;
          if (!frame_open_q) begin
            state_d = S_STB_SETUP;
            cnt_d   = DIV_LOAD;
          end else if (req_read) begin
            state_d = S_RD_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_BIT_LO;
            cnt_d   = DIV_LOAD;
          end
        end
      end
      S_STB_SETUP: begin
        if (phase_done) begin
          frame_open_d = 1'b1;
          state_d      = read_q ? S_RD_WAIT : S_BIT_LO;
          cnt_d        = read_q ? WAIT_LOAD : DIV_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RD_WAIT, S_BIT_LO: begin
        if (phase_done) begin
          state_d = (state_q == S_RD_WAIT) ? S_BIT_LO : S_BIT_HI;
          cnt_d   = DIV_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_BIT_HI: begin
        if (phase_done) begin
          cnt_d = DIV_LOAD;
          if (read_q) shift_d = shift_in;
          if (bit_q == 3'd7) begin
            state_d = last_q ? S_STB_HOLD : S_GAP;
            if (read_q) begin
              rsp_byte_d  = shift_in;
              rsp_valid_d = 1'b1;
            end
          end else begin
            state_d = S_BIT_LO;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP, S_STB_HIGH: begin
        if (phase_done) state_d = S_IDLE;
        else            cnt_d   = cnt_q - CNT_ONE;
      end
      S_STB_HOLD: begin
        if (phase_done) begin
          state_d      = S_STB_HIGH;
          cnt_d        = DIV_LOAD;
          frame_open_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode from the next state.
  always_comb begin
    stb_d = 1'b0;
    clk_d = 1'b1;
    oe_d  = 1'b0;
    out_d = 1'b1;
    unique case (state_d)
      S_IDLE:     stb_d = !frame_open_d;
      S_BIT_LO: begin
        clk_d = 1'b0;
        oe_d  = !read_d;
      end
      S_BIT_HI:   oe_d  = !read_d;
      S_STB_HIGH: stb_d = 1'b1;
      default:    ;
    endcase
    if (oe_d) out_d = byte_d[bit_d];
  end

endmodule

// File: tb/tb_tm1638_serial_io.sv
// tb/tb_tm1638_serial_io.sv - self-checking bench for tm1638_serial_io
module tb_tm1638_serial_io;
  localparam int D  = 4;
  localparam int RW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_byte = 8'h00;
  logic       req_read = 1'b0;
  logic       req_last = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_byte;
  logic       tm_stb, tm_clk, tm_dio_out, tm_dio_oe;
  logic       tm_dio_in = 1'b1;

  tm1638_serial_io #(.CLK_DIV(D), .READ_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_byte(req_byte), .req_read(req_read), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .tm_stb(tm_stb),
    .tm_clk(tm_clk), .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe),
    .tm_dio_in(tm_dio_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Behavioural model: one request is a timeline of offsets after the
  // accept clock; outputs follow from the segment the offset falls in.
  logic       m_active = 1'b0;
  logic       m_frame_open = 1'b0;
  logic       m_read = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_rsp_valid = 1'b0;
  logic [7:0] m_rsp_byte = 8'h00;
  int         m_k = 0, m_S = 0, m_W = 0, m_E = 0;
  logic [7:0] chip_byte = 8'h00;

  initial forever begin
    @(posedge clk);
    m_rsp_valid = 1'b0;
    if (rst) begin
      m_active     = 1'b0;
      m_frame_open = 1'b0;
      m_rsp_byte   = 8'h00;
    end else if (m_active) begin
      m_k++;
      if (m_read && m_k == m_S + m_W + 16*D + 1) begin
        m_rsp_valid = 1'b1;
        m_rsp_byte  = chip_byte;
      end
      if (m_k > m_S + m_W + 16*D + m_E) m_active = 1'b0;
    end else if (req_valid) begin
      m_S          = m_frame_open ? 0 : D;
      m_W          = req_read ? RW : 0;
      m_E          = req_last ? 2*D : D;
      m_read       = req_read;
      m_byte       = req_byte;
      m_frame_open = !req_last;
      m_k          = 1;
      m_active     = 1'b1;
    end
  end

  function automatic logic [13:0] model_out();
    logic stb, ck, oe, o;
    int b0, j;
    stb = !m_frame_open; ck = 1'b1; oe = 1'b0; o = 1'b1;
    if (m_active) begin
      stb = 1'b0;
      b0  = m_S + m_W;
      if (m_k > b0 && m_k <= b0 + 16*D) begin
        j  = m_k - b0 - 1;
        ck = (j % (2*D)) >= D;
        if (!m_read) begin
          oe = 1'b1;
          o  = m_byte[j / (2*D)];
        end
      end else if (m_k > b0 + 16*D) begin
        if (m_k - b0 - 16*D > D) stb = 1'b1;
      end
    end
    return {stb, ck, oe, o, !rst && !m_active, m_rsp_valid, m_rsp_byte};
  endfunction

  initial forever begin
    logic [13:0] exp_v, got_v;
    @(posedge clk); #1;
    exp_v = model_out();
    got_v = {tm_stb, tm_clk, tm_dio_oe, tm_dio_out, req_ready, rsp_valid, rsp_byte};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_compare cyc=%0d got=%h exp=%h", cyc, got_v, exp_v);
    end
  end

  // Chip model: shifts the read byte out LSB first after each CLK fall.
  logic chip_en = 1'b0;
  int   chip_idx = 0;
  initial forever begin
    @(negedge tm_clk);
    if (chip_en) begin
      tm_dio_in = chip_byte[chip_idx % 8];
      chip_idx++;
    end
  end

  // Waveform monitors.
  int   fall_q[$];
  logic bit_q[$];
  int   stb_runs[$];
  int   rsp_cyc_q[$];
  logic [7:0] rsp_val_q[$];
  int   stb_run = 0;
  logic prev_clk = 1'b1;
  int   acc_cnt = 0;

  initial forever begin
    @(posedge clk); #1;
    if (prev_clk && !tm_clk) fall_q.push_back(cyc);
    if (!prev_clk && tm_clk && tm_dio_oe) bit_q.push_back(tm_dio_out);
    prev_clk = tm_clk;
    if (!tm_stb) stb_run++;
    else if (stb_run > 0) begin
      stb_runs.push_back(stb_run);
      stb_run = 0;
    end
    if (rsp_valid) begin
      rsp_cyc_q.push_back(cyc);
      rsp_val_q.push_back(rsp_byte);
    end
  end

  initial forever begin
    @(posedge clk);
    if (req_valid && req_ready) acc_cnt++;
  end

  task automatic clear_mon();
    fall_q.delete(); bit_q.delete(); stb_runs.delete();
    rsp_cyc_q.delete(); rsp_val_q.delete();
  endtask

  function automatic logic [7:0] asm_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = (base + i < bit_q.size()) ? bit_q[base + i] : 1'bx;
    return r;
  endfunction

  // Offers a request (called at a negedge) and returns at the negedge after
  // the accept clock; req_valid is left high for the caller to drop.
  task automatic send(input logic [7:0] b, input logic rd, input logic lst, output int acc);
    logic r;
    req_valid = 1'b1; req_byte = b; req_read = rd; req_last = lst;
    acc = -1;
    for (int n = 0; n < 2000; n++) begin
      r = req_ready;
      @(posedge clk); #1;
      if (r) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("send_accept", acc >= 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int n = 0; n < 2000; n++) begin
      if (req_ready) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("idle_timeout", c >= 0, 1);
  endtask

  initial begin
    int a1, a2, c;
    logic [7:0] qb [3];
    logic       ql [3];

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_stb", tm_stb, 1);
    chk("rst_clk", tm_clk, 1);
    chk("rst_oe", tm_dio_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_byte", rsp_byte, 8'h00);
    chk("rst_ready_low", req_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);
    repeat (2) @(negedge clk);

    // Single write 0x8F, last
    clear_mon();
    send(8'h8F, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle(c);
    chk("wr_ready_lat", c - a1 + 1, 77);
    repeat (3) @(negedge clk);
    chk("wr_stb_runs", stb_runs.size(), 1);
    if (stb_runs.size() > 0) chk("wr_stb_low", stb_runs[0], 72);
    chk("wr_bits", bit_q.size(), 8);
    chk("wr_dio", asm_byte(0), 8'h8F);
    chk("wr_first_fall", (fall_q.size() > 0) ? fall_q[0] - a1 + 1 : -1, 5);

    // Two-byte frame
    clear_mon();
    send(8'hC0, 1'b0, 1'b0, a1);
    send(8'h3F, 1'b0, 1'b1, a2);
    req_valid = 1'b0;
    wait_idle(c);
    repeat (3) @(negedge clk);
    chk("frm_stb_runs", stb_runs.size(), 1);
    if (stb_runs.size() > 0) chk("frm_stb_low", stb_runs[0], 141);
    chk("frm_b0", asm_byte(0), 8'hC0);
    chk("frm_b1", asm_byte(8), 8'h3F);
    chk("frm_falls", fall_q.size(), 16);
    if (fall_q.size() == 16) chk("frm_no_setup", fall_q[8] - a2 + 1, 1);

    // Write then read in one frame
    clear_mon();
    send(8'h42, 1'b0, 1'b0, a1);
    req_valid = 1'b0;
    wait_idle(c);
    chip_byte = 8'hA5; chip_idx = 0; chip_en = 1'b1;
    send(8'h00, 1'b1, 1'b1, a2);
    req_valid = 1'b0;
    chk("rd_wait_oe", tm_dio_oe, 0);
    chk("rd_wait_clk", tm_clk, 1);
    wait_idle(c);
    chip_en = 1'b0; tm_dio_in = 1'b1;
    chk("rd_wr_byte", asm_byte(0), 8'h42);
    chk("rd_pulses", rsp_cyc_q.size(), 1);
    if (rsp_cyc_q.size() > 0) begin
      chk("rd_lat", rsp_cyc_q[0] - a2 + 1, 73);
      chk("rd_byte", rsp_val_q[0], 8'hA5);
    end
    repeat (100) @(negedge clk);
    chk("rd_hold", rsp_byte, 8'hA5);

    // Reset during bit 3 of a write
    clear_mon();
    send(8'h5A, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stb", tm_stb, 1);
    chk("mid_rst_clk", tm_clk, 1);
    chk("mid_rst_oe", tm_dio_oe, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    send(8'h01, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    chk("post_rst_setup_stb", tm_stb, 0);
    chk("post_rst_setup_clk", tm_clk, 1);
    wait_idle(c);
    chk("post_rst_fall", (fall_q.size() > 0) ? fall_q[0] - a1 + 1 : -1, 5);
    chk("post_rst_dio", asm_byte(0), 8'h01);
    chk("post_rst_no_rsp", rsp_cyc_q.size(), 0);

    // Three queued writes with req_valid held high
    repeat (3) @(negedge clk);
    clear_mon();
    acc_cnt = 0;
    qb[0] = 8'h11; qb[1] = 8'h22; qb[2] = 8'h33;
    ql[0] = 1'b0;  ql[1] = 1'b0;  ql[2] = 1'b1;
    for (int i = 0; i < 3; i++) send(qb[i], 1'b0, ql[i], a1);
    req_valid = 1'b0;
    wait_idle(c);
    repeat (5) @(negedge clk);
    chk("q_accepts", acc_cnt, 3);
    chk("q_b0", asm_byte(0), 8'h11);
    chk("q_b1", asm_byte(8), 8'h22);
    chk("q_b2", asm_byte(16), 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
